// File: rtl/sprite_drawer_if.sv
// sprite_drawer_if: request/done handshake, sprite ROM ports and VGA plot stream of the sprite drawer.
interface sprite_drawer_if #(
    parameter int SPRITE_W = 8,
    parameter int SPRITE_H = 12,
    parameter int COLOUR_W = 9
);
    localparam int AW = $clog2(SPRITE_W * SPRITE_H);
    logic                drawBG;
    logic                drawChar;
    logic [8:0]          xCoordinate;
    logic [7:0]          yCoordinate;
    logic                doneBG;
    logic                doneChar;
    logic [AW-1:0]       charAddr;
    logic [COLOUR_W-1:0] charData;
    logic [16:0]         bgAddr;
    logic [COLOUR_W-1:0] bgData;
    logic [8:0]          vgaX;
    logic [7:0]          vgaY;
    logic [COLOUR_W-1:0] vgaColour;
    logic                vgaPlot;
    modport master (
        output drawBG, drawChar, xCoordinate, yCoordinate, charData, bgData,
        input  doneBG, doneChar, charAddr, bgAddr, vgaX, vgaY, vgaColour, vgaPlot
    );
    modport slave (
        input  drawBG, drawChar, xCoordinate, yCoordinate, charData, bgData,
        output doneBG, doneChar, charAddr, bgAddr, vgaX, vgaY, vgaColour, vgaPlot
    );
endinterface

// File: rtl/sprite_drawer.sv
// sprite_drawer: sweeps a sprite window and plots background (erase) or character (draw) pixels to VGA.
module sprite_drawer #(
    parameter int SPRITE_W = 8,
    parameter int SPRITE_H = 12,
    parameter int COLOUR_W = 9,
    parameter logic [COLOUR_W-1:0] TRANSPARENT = 9'h1C7
) (
    input logic clock,
    input logic resetn,
    sprite_drawer_if.slave bus
);
    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);
    localparam int AW = $clog2(SPRITE_W * SPRITE_H);

    typedef enum logic [1:0] {IDLE, SWEEP, FLUSH, DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [9:0]    x0_q;
    logic [9:0]    y0_q;
    logic          mode_bg_q;
    logic          valid_q;
    logic          done_bg_q;
    logic          done_char_q;
    logic [8:0]    px_q;
    logic [7:0]    py_q;
    logic [10:0]   px_d;
    logic [10:0]   py_d;
    logic          sweeping;
    logic          on_screen;
    logic          last_col;
    logic          last_row;

    // Origin is signed, so a window hanging off the top/left yields negative px/py.
    assign sweeping  = state_q == SWEEP;
    assign px_d      = {x0_q[9], x0_q} + 11'(col_q);
    assign py_d      = {y0_q[9], y0_q} + 11'(row_q);
    assign on_screen = !px_d[10] && !py_d[10] && px_d < 11'd320 && py_d < 11'd240;
    assign last_col  = col_q == CW'(SPRITE_W - 1);
    assign last_row  = row_q == RW'(SPRITE_H - 1);

    assign bus.charAddr  = sweeping ? AW'(row_q) * AW'(SPRITE_W) + AW'(col_q) : '0;
    assign bus.bgAddr    = sweeping && on_screen ?
                           17'({py_d[7:0], 8'd0}) + 17'({py_d[7:0], 6'd0}) + 17'(px_d[8:0]) : '0;
    assign bus.vgaPlot   = valid_q && (mode_bg_q || bus.charData != TRANSPARENT);
    assign bus.vgaColour = valid_q ? (mode_bg_q ? bus.bgData : bus.charData) : '0;
    assign bus.vgaX      = px_q;
    assign bus.vgaY      = py_q;
    assign bus.doneBG    = done_bg_q;
    assign bus.doneChar  = done_char_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            x0_q        <= '0;
            y0_q        <= '0;
            mode_bg_q   <= 1'b0;
            valid_q     <= 1'b0;
            done_bg_q   <= 1'b0;
            done_char_q <= 1'b0;
            px_q        <= '0;
            py_q        <= '0;
        end else begin
            valid_q <= sweeping && on_screen;
            if (sweeping) begin
                px_q <= px_d[8:0];
                py_q <= py_d[7:0];
            end
            case (state_q)
                IDLE: if (bus.drawBG || bus.drawChar) begin
                    state_q   <= SWEEP;
                    mode_bg_q <= bus.drawBG;
                    x0_q      <= {1'b0, bus.xCoordinate} - 10'(SPRITE_W / 2);
                    y0_q      <= {2'b0, bus.yCoordinate} - 10'(SPRITE_H - 1);
                end
                SWEEP: begin
                    col_q <= last_col ? '0 : col_q + CW'(1);
                    if (last_col) begin
                        row_q <= last_row ? '0 : row_q + RW'(1);
                        if (last_row) state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    state_q     <= DONE;
                    done_bg_q   <= mode_bg_q;
                    done_char_q <= !mode_bg_q;
                end
                DONE: if (!(mode_bg_q ? bus.drawBG : bus.drawChar)) begin
                    state_q     <= IDLE;
                    done_bg_q   <= 1'b0;
                    done_char_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_drawer.sv
// tb_sprite_drawer: scoreboard bench; a reference sweep queues expected plots, the monitor pops and compares them.
module tb_sprite_drawer;
    localparam int W = 8;
    localparam int H = 12;
    localparam int N = W * H;
    localparam logic [8:0] TR = 9'h1C7;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    sprite_drawer_if #(.SPRITE_W(W), .SPRITE_H(H), .COLOUR_W(9)) bus();
    sprite_drawer #(.SPRITE_W(W), .SPRITE_H(H), .COLOUR_W(9), .TRANSPARENT(TR)) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int plots = 0;
    int cyc = 0;
    bit char_pat = 1'b0;
    logic [63:0] sb[$];

    always @(posedge clock) cyc <= cyc + 1;

    // ROM models: one-cycle synchronous reads
    always @(posedge clock) begin
        bus.bgData   <= bus.bgAddr[8:0];
        bus.charData <= (char_pat && bus.charAddr < 7'd8) ? TR : 9'h0FF;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (resetn && bus.vgaPlot) begin
            logic [63:0] e;
            plots++;
            if (sb.size() == 0) check("extra_plot", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                check("plot", {22'd0, 16'(cyc), bus.vgaX, bus.vgaY, bus.vgaColour}, e);
            end
        end
    end

    task automatic push_exp(input bit bg, input int x, input int y, input int r);
        for (int row = 0; row < H; row++)
            for (int col = 0; col < W; col++) begin
                int px, py;
                px = x - W / 2 + col;
                py = y - (H - 1) + row;
                if (px >= 0 && px < 320 && py >= 0 && py < 240 && (bg || !(char_pat && row == 0)))
                    sb.push_back({22'd0, 16'(r + 1 + row * W + col), 9'(px), 8'(py),
                                  bg ? 9'((py * 320 + px) % 512) : 9'h0FF});
            end
    endtask

    function automatic logic [63:0] outs();
        return {11'd0, bus.bgAddr, bus.charAddr, bus.vgaX, bus.vgaY, bus.vgaColour,
                bus.vgaPlot, bus.doneBG, bus.doneChar};
    endfunction

    task automatic run(input bit bg, input int x, input int y, input int hold, input int drop, input int exp_n);
        int r;
        int dcyc;
        @(negedge clock);
        bus.xCoordinate = 9'(x);
        bus.yCoordinate = 8'(y);
        if (bg) bus.drawBG = 1'b1;
        else bus.drawChar = 1'b1;
        @(posedge clock);
        #1 r = cyc;
        plots = 0;
        push_exp(bg, x, y, r);
        dcyc = -1;
        for (int k = 0; k < 200 && dcyc < 0; k++) begin
            @(negedge clock);
            if (drop > 0 && cyc == r + drop) begin
                bus.drawBG = 1'b0;
                bus.drawChar = 1'b0;
            end
            if (bg ? bus.doneBG : bus.doneChar) dcyc = cyc;
        end
        check("done_cyc", 64'(dcyc), 64'(r + 1 + N));
        check("other_done", 64'(bg ? bus.doneChar : bus.doneBG), 64'd0);
        check("plot_cnt", 64'(plots), 64'(exp_n));
        check("sb_empty", 64'(sb.size()), 64'd0);
        if (drop > 0) begin
            @(negedge clock);
            check("done_pulse", 64'(bg ? bus.doneBG : bus.doneChar), 64'd0);
        end else begin
            repeat (hold) @(negedge clock);
            check("done_held", 64'(bg ? bus.doneBG : bus.doneChar), 64'd1);
            bus.drawBG = 1'b0;
            bus.drawChar = 1'b0;
            @(negedge clock);
            check("done_fall", 64'(bg ? bus.doneBG : bus.doneChar), 64'd0);
        end
        repeat (5) @(negedge clock);
        check("idle_quiet", 64'({bus.doneBG, bus.doneChar, bus.vgaPlot}), 64'd0);
    endtask

    task automatic reset_abort();
        int r;
        @(negedge clock);
        bus.xCoordinate = 9'd95;
        bus.yCoordinate = 8'd221;
        bus.drawBG = 1'b1;
        @(posedge clock);
        #1 r = cyc;
        push_exp(1'b1, 95, 221, r);
        while (cyc < r + 39) @(negedge clock);
        resetn = 1'b0;
        bus.drawBG = 1'b0;
        @(posedge clock);
        #1 sb.delete();
        check("abort_outs", outs(), 64'd0);
        repeat (4) @(negedge clock);
        check("abort_nodone", outs(), 64'd0);
        resetn = 1'b1;
    endtask

    initial begin
        bus.drawBG = 1'b0;
        bus.drawChar = 1'b0;
        bus.xCoordinate = '0;
        bus.yCoordinate = '0;
        repeat (3) @(posedge clock);
        #1 check("reset_outs", outs(), 64'd0);
        @(negedge clock);
        resetn = 1'b1;
        run(1'b1, 95, 221, 3, 0, 96);
        char_pat = 1'b1;
        run(1'b0, 95, 221, 3, 0, 88);
        char_pat = 1'b0;
        run(1'b1, 2, 5, 3, 0, 36);
        run(1'b0, 320, 240, 3, 0, 44);
        run(1'b0, 95, 221, 20, 0, 96);
        run(1'b0, 95, 221, 0, 29, 96);
        reset_abort();
        run(1'b1, 95, 221, 2, 0, 96);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sprite_drawer.md
# sprite_drawer

Pixel-sweep engine directly downstream of the sprite movement FSM. On a level request from `drawBG` or `drawChar` it latches the character anchor, then sweeps a fixed SPRITE_W×SPRITE_H window. For each pixel it reads either the background ROM (erase) or the character ROM (draw) and emits plot writes to the 320×240 VGA adapter. It answers the mover with a four-phase `doneBG` / `doneChar` handshake.

## Interface

Parameters:
- SPRITE_W, 8, sprite width in pixels.
- SPRITE_H, 12, sprite height in pixels.
- COLOUR_W, 9, colour width (3 bits per channel).
- TRANSPARENT, 9'h1C7, character colour key that is never plotted.

Ports:
- clock  in  1  system clock.
- resetn  in  1  reset resetn, synchronous, active-low; clock clock.
- drawBG  in  1  level request to erase the sprite window with background.
- drawChar  in  1  level request to draw the character.
- xCoordinate  in  9  anchor X, bottom-centre of the sprite.
- yCoordinate  in  8  anchor Y, bottom row of the sprite.
- doneBG  out  1  erase complete; held until `drawBG` falls.
- doneChar  out  1  draw complete; held until `drawChar` falls.
- charAddr  out  clog2(W*H)  character ROM address, row*SPRITE_W+col.
- charData  in  COLOUR_W  character ROM data; synchronous, 1-cycle latency.
- bgAddr  out  17  background ROM address, y*320+x.
- bgData  in  COLOUR_W  background ROM data; synchronous, 1-cycle latency.
- vgaX  out  9  plot X.
- vgaY  out  8  plot Y.
- vgaColour  out  COLOUR_W  plot colour.
- vgaPlot  out  1  write strobe, one pixel per cycle.

## Operation

- States: IDLE, SWEEP, FLUSH, DONE.
- IDLE → SWEEP when `drawBG` or `drawChar` is high.
  - On that edge: latch mode (BG wins if both are high) and origin x0 = X − SPRITE_W/2, y0 = Y − (SPRITE_H−1).
  - Origin uses 10-bit signed arithmetic, so an underflow goes negative rather than wrapping.
- SWEEP: col counts 0..SPRITE_W−1 fastest, row counts 0..SPRITE_H−1.
  - One pixel address is issued per cycle. px = x0+col, py = y0+row.
  - Both ROM addresses are driven every cycle.
  - For an off-screen pixel (px<0, px≥320, py<0, py≥240): bgAddr=0 and the pixel is marked invalid.
- Pipeline stage 2: px, py, valid and mode are registered alongside the ROM read.
  - Next cycle: vgaPlot = valid AND (mode==BG OR charData≠TRANSPARENT).
  - vgaColour = bgData or charData according to mode.
  - vgaX / vgaY are the low 9/8 bits of px/py.
- SWEEP → FLUSH after the last pixel (col=W−1, row=H−1) is issued. FLUSH emits the last plot, then goes to DONE.
- DONE: assert the done output of the latched mode. Go to IDLE in the first cycle the latched request input is low; done deasserts with that transition.
- A request that drops mid-sweep is ignored. The sweep completes and DONE lasts exactly 1 cycle.
- Requests are re-sampled only in IDLE, so a still-high request after DONE can never retrigger.
- Anchor (320,240) gives a partially on-screen window; only on-screen pixels are plotted and done is still produced.

## Timing

- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-sweep aborts immediately with no done and no further plots.
- Timing is relative to request sampled high in IDLE at edge t, with N = SPRITE_W·SPRITE_H.
- Pixel i address is driven in cycle t+1+i. Its plot (if any) is in cycle t+2+i.
- Last plot is at t+1+N (FLUSH). Done first rises at t+2+N; default N=96 gives t+98.
- At most one plot per cycle. The plot stream is strictly row-major.
- bgAddr arithmetic: py·320 = (py<<8)+(py<<6), 17 bits, no overflow for py≤239.

## Test plan

- Erase at anchor (95,221), bgData = address low bits → 96 plots covering x 91..98, y 210..221, first plot (91,210) at t+2. doneBG rises at t+98 and holds until `drawBG` low, then IDLE next cycle.
- Draw at (95,221) with charData = TRANSPARENT for addresses 0..7, other data = 9'h0FF → exactly 88 plots, none on row y=210, colour 9'h0FF. doneChar at t+98.
- Clipping: drawBG at (2,5) → origin (−2,−6); only 36 plots (x 0..5, y 0..5), no vgaX/vgaY wrap values. doneBG at t+98.
- Finish location (320,240), drawChar with opaque data → plots only x 316..319, y 229..239 (44 plots). doneChar still asserted.
- Handshake: drawChar held high 20 cycles after doneChar → no second sweep. Dropping drawChar at t+30 → sweep completes and doneChar pulses 1 cycle at t+98.
- resetn low at t+40 during a sweep → next cycle all outputs 0, no done. A new request after reset gives a full 96-cycle sweep.
